// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control unit: opcodes, state
// encoding, datapath mux encodings and the control-vector record.
package mips_pkg;

  // Opcodes recognised by the controller (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // State encoding, visible on the debug state port
  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_MEMADR = 4'd2;
  localparam logic [3:0] ST_MEMRD  = 4'd3;
  localparam logic [3:0] ST_MEMWB  = 4'd4;
  localparam logic [3:0] ST_MEMWR  = 4'd5;
  localparam logic [3:0] ST_RTEXE  = 4'd6;
  localparam logic [3:0] ST_RTWB   = 4'd7;
  localparam logic [3:0] ST_BEQ    = 4'd8;
  localparam logic [3:0] ST_IMMEXE = 4'd9;
  localparam logic [3:0] ST_IMMWB  = 4'd10;
  localparam logic [3:0] ST_JUMP   = 4'd11;

  typedef enum logic [3:0] {
    S_FETCH  = ST_FETCH,
    S_DECODE = ST_DECODE,
    S_MEMADR = ST_MEMADR,
    S_MEMRD  = ST_MEMRD,
    S_MEMWB  = ST_MEMWB,
    S_MEMWR  = ST_MEMWR,
    S_RTEXE  = ST_RTEXE,
    S_RTWB   = ST_RTWB,
    S_BEQ    = ST_BEQ,
    S_IMMEXE = ST_IMMEXE,
    S_IMMWB  = ST_IMMWB,
    S_JUMP   = ST_JUMP
  } state_e;

  // ALU operation select
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_LOGIC = 2'b11;

  // ALU B-operand select
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Full control vector driven towards the datapath
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       ext_sel;
  } ctrl_t;

  // True for every opcode the controller knows how to sequence
  function automatic logic op_is_legal(input logic [5:0] op);
    logic legal;
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_ADDI,
      OP_ANDI, OP_ORI, OP_LW, OP_SW: legal = 1'b1;
      default:                       legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational state+opcode -> control-vector decoder. Outputs depend on
// state only, except the FETCH register enables which wait for mem_ready and
// the IMMEXE extender/ALU mode which follows the immediate opcode.
module mips_ctrl_outdec
  import mips_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  // Per-state control vector; everything idle except sign-extension
  always_comb begin
    ctrl_o         = '0;
    ctrl_o.ext_sel = 1'b1;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_req   = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM_SH;
      end
      S_MEMADR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.mem_we  = 1'b1;
        ctrl_o.iord    = 1'b1;
      end
      S_RTEXE: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_RTWB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_BEQ: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_src        = PCSRC_ALUOUT;
      end
      S_IMMEXE: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        // Logical immediates are zero-extended; addi stays signed
        if ((opcode_i == OP_ANDI) || (opcode_i == OP_ORI)) begin
          ctrl_o.ext_sel = 1'b0;
          ctrl_o.alu_op  = ALUOP_LOGIC;
        end else begin
          ctrl_o.ext_sel = 1'b1;
          ctrl_o.alu_op  = ALUOP_ADD;
        end
      end
      S_IMMWB: begin
        ctrl_o.reg_write = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_write = 1'b1;
        ctrl_o.pc_src   = PCSRC_JUMP;
      end
      default: begin
        ctrl_o.ext_sel = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: state register, next-state sequencing and the
// registered illegal-opcode pulse. Control outputs come from mips_ctrl_outdec.
module mips_multicycle_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  input  logic       zero,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       ext_sel,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  ctrl_t  ctrl_s;
  // The branch decision is resolved in the datapath from pc_write_cond
  logic   unused_zero_s;

  assign unused_zero_s = zero;

  mips_ctrl_outdec u_outdec (
    .state_i     (state_q),
    .opcode_i    (opcode),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl_s)
  );

  // Next-state sequencing; memory states hold until mem_ready
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:              state_d = S_MEMADR;
          OP_RTYPE:                  state_d = S_RTEXE;
          OP_BEQ:                    state_d = S_BEQ;
          OP_ADDI, OP_ANDI, OP_ORI:  state_d = S_IMMEXE;
          OP_J:                      state_d = S_JUMP;
          default:                   state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_RTEXE:  state_d = S_RTWB;
      S_RTWB:   state_d = S_FETCH;
      S_BEQ:    state_d = S_FETCH;
      S_IMMEXE: state_d = S_IMMWB;
      S_IMMWB:  state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Unknown opcode in DECODE raises illegal_op for the following cycle only
  always_comb begin
    if (state_q == S_DECODE) begin
      illegal_d = ~op_is_legal(opcode);
    end else begin
      illegal_d = 1'b0;
    end
  end

  // State and illegal-flag registers; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // FETCH enables are additionally blocked while reset is held
  assign ir_write      = ctrl_s.ir_write & rst_n;
  assign pc_write      = ctrl_s.pc_write & rst_n;
  assign mem_req       = ctrl_s.mem_req;
  assign mem_we        = ctrl_s.mem_we;
  assign iord          = ctrl_s.iord;
  assign pc_write_cond = ctrl_s.pc_write_cond;
  assign reg_write     = ctrl_s.reg_write;
  assign reg_dst       = ctrl_s.reg_dst;
  assign mem_to_reg    = ctrl_s.mem_to_reg;
  assign alu_src_a     = ctrl_s.alu_src_a;
  assign alu_src_b     = ctrl_s.alu_src_b;
  assign alu_op        = ctrl_s.alu_op;
  assign pc_src        = ctrl_s.pc_src;
  assign ext_sel       = ctrl_s.ext_sel;
  assign illegal_op    = illegal_q;
  assign state         = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: a directed vector table,
// hand-written wait/reset sequences and randomized instruction streams, all
// checked against an instruction-level phase model.
module tb_mips_multicycle_ctrl;
  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       zero = 1'b0;
  logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a, ext_sel, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .ext_sel(ext_sel),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Instruction-level model: current phase, remaining phases, pending pulse
  logic [3:0] m_phase = ST_FETCH;
  logic [3:0] m_plan[$];
  logic       m_ill = 1'b0;
  logic [21:0] last_act;

  typedef struct {
    logic [5:0]  op;
    logic        rdy;
    logic        z;
    logic [12:0] exp;
  } vec_t;
  vec_t tbl[30];

  function automatic logic [12:0] tv(input logic [3:0] st, input logic req, input logic we,
                                     input logic rw, input logic ext, input logic [1:0] ao,
                                     input logic [1:0] ps, input logic ill);
    return {st, req, we, rw, ext, ao, ps, ill};
  endfunction

  // Expected outputs for a phase, written straight from the per-state table
  function automatic logic [21:0] m_expect(input logic [3:0] ph, input logic [5:0] op,
                                           input logic rdy, input logic ill);
    logic req, we, io, irw, pcw, pcwc, rw, rdst, m2r, sa, ext;
    logic [1:0] sb, ao, ps;
    {req, we, io, irw, pcw, pcwc, rw, rdst, m2r, sa} = 10'd0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00; ext = 1'b1;
    case (ph)
      ST_FETCH:  begin req = 1'b1; sb = 2'b01; irw = rdy; pcw = rdy; end
      ST_DECODE: sb = 2'b11;
      ST_MEMADR: begin sa = 1'b1; sb = 2'b10; end
      ST_MEMRD:  begin req = 1'b1; io = 1'b1; end
      ST_MEMWB:  begin rw = 1'b1; m2r = 1'b1; end
      ST_MEMWR:  begin req = 1'b1; we = 1'b1; io = 1'b1; end
      ST_RTEXE:  begin sa = 1'b1; ao = 2'b10; end
      ST_RTWB:   begin rw = 1'b1; rdst = 1'b1; end
      ST_BEQ:    begin sa = 1'b1; ao = 2'b01; pcwc = 1'b1; ps = 2'b01; end
      ST_IMMEXE: begin
        sa = 1'b1; sb = 2'b10;
        if (op == 6'b001100 || op == 6'b001101) begin ext = 1'b0; ao = 2'b11; end
      end
      ST_IMMWB:  rw = 1'b1;
      ST_JUMP:   begin pcw = 1'b1; ps = 2'b10; end
      default:   req = 1'bx;
    endcase
    return {req, we, io, irw, pcw, pcwc, rw, rdst, m2r, sa, sb, ao, ps, ext, ill, ph};
  endfunction

  // Advance the model one clock: memory phases wait, DECODE plans the instruction
  task automatic m_advance(input logic [5:0] op, input logic rdy);
    m_ill = 1'b0;
    if ((m_phase == ST_FETCH || m_phase == ST_MEMRD || m_phase == ST_MEMWR) && !rdy) return;
    if (m_phase == ST_FETCH) begin
      m_phase = ST_DECODE;
    end else begin
      if (m_phase == ST_DECODE) begin
        m_plan.delete();
        case (op)
          6'b100011: m_plan = {ST_MEMADR, ST_MEMRD, ST_MEMWB};
          6'b101011: m_plan = {ST_MEMADR, ST_MEMWR};
          6'b000000: m_plan = {ST_RTEXE, ST_RTWB};
          6'b000100: m_plan = {ST_BEQ};
          6'b001000, 6'b001100, 6'b001101: m_plan = {ST_IMMEXE, ST_IMMWB};
          6'b000010: m_plan = {ST_JUMP};
          default:   m_ill = 1'b1;
        endcase
      end
      m_phase = (m_plan.size() > 0) ? m_plan.pop_front() : ST_FETCH;
    end
  endtask

  task automatic m_reset();
    m_phase = ST_FETCH;
    m_plan.delete();
    m_ill = 1'b0;
  endtask

  // One clock: drive at the falling edge, check before the next rising edge
  task automatic apply(input logic [5:0] op, input logic rdy, input logic z,
                       input logic use_tbl, input logic [12:0] texp, input string tag);
    logic [21:0] exp, act;
    logic [12:0] tact;
    opcode = op; mem_ready = rdy; zero = z;
    #1;
    act = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, ext_sel, illegal_op, state};
    last_act = act;
    exp = m_expect(m_phase, op, rdy, m_ill);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL model_%s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
    if (use_tbl) begin
      tact = {state, mem_req, mem_we, reg_write, ext_sel, alu_op, pc_src, illegal_op};
      n_vec++;
      if (tact !== texp) begin
        n_bad++;
        $display("FAIL table_%s: got %h expected %h (t=%0t)", tag, tact, texp, $time);
      end
    end
    m_advance(op, rdy);
    @(negedge clk);
  endtask

  logic [5:0] legal_ops[8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                               6'b001000, 6'b001100, 6'b001101, 6'b000010};

  initial begin : main
    int hold;
    logic [5:0] rop;
    logic [7:0] rchk;

    // lw, andi, addi, beq taken / not taken, illegal, j, R-type
    tbl[0]  = '{6'b100011, 1'b1, 1'b0, tv(ST_FETCH,  1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0)};
    tbl[1]  = '{6'b100011, 1'b1, 1'b0, tv(ST_DECODE, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0)};
    tbl[2]  = '{6'b100011, 1'b1, 1'b0, tv(ST_MEMADR, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0)};
    tbl[3]  = '{6'b100011, 1'b1, 1'b0, tv(ST_MEMRD,  1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0)};
    tbl[4]  = '{6'b100011, 1'b1, 1'b0, tv(ST_MEMWB,  1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0)};
    tbl[5]  = '{6'b001100, 1'b1, 1'b0, tv(ST_FETCH,  1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0)};
    tbl[6]  = '{6'b001100, 1'b1, 1'b0, tv(ST_DECODE, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0)};
    tbl[7]  = '{6'b001100, 1'b1, 1'b0, tv(ST_IMMEXE, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0)};
    tbl[8]  = '{6'b001100, 1'b1, 1'b0, tv(ST_IMMWB,  1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0)};
    tbl[9]  = '{6'b001000, 1'b1, 1'b0, tv(ST_FETCH,  1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0)};
    tbl[10] = '{6'b001000, 1'b1, 1'b0, tv(ST_DECODE, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0)};
    tbl[11] = '{6'b001000, 1'b1, 1'b0, tv(ST_IMMEXE, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0)};
    tbl[12] = '{6'b001000, 1'b1, 1'b0, tv(ST_IMMWB,  1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0)};
    tbl[13] = '{6'b000100, 1'b1, 1'b1, tv(ST_FETCH,  1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0)};
    tbl[14] = '{6'b000100, 1'b1, 1'b1, tv(ST_DECODE, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0)};
    tbl[15] = '{6'b000100, 1'b1, 1'b1, tv(ST_BEQ,    1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b01, 1'b0)};
    tbl[16] = '{6'b000100, 1'b1, 1'b0, tv(ST_FETCH,  1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0)};
    tbl[17] = '{6'b000100, 1'b1, 1'b0, tv(ST_DECODE, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0)};
    tbl[18] = '{6'b000100, 1'b1, 1'b0, tv(ST_BEQ,    1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b01, 1'b0)};
    tbl[19] = '{6'b111111, 1'b1, 1'b0, tv(ST_FETCH,  1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0)};
    tbl[20] = '{6'b111111, 1'b1, 1'b0, tv(ST_DECODE, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0)};
    tbl[21] = '{6'b111111, 1'b0, 1'b0, tv(ST_FETCH,  1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1)};
    tbl[22] = '{6'b111111, 1'b0, 1'b0, tv(ST_FETCH,  1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0)};
    tbl[23] = '{6'b000010, 1'b1, 1'b0, tv(ST_FETCH,  1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0)};
    tbl[24] = '{6'b000010, 1'b1, 1'b0, tv(ST_DECODE, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0)};
    tbl[25] = '{6'b000010, 1'b1, 1'b0, tv(ST_JUMP,   1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0)};
    tbl[26] = '{6'b000000, 1'b1, 1'b0, tv(ST_FETCH,  1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0)};
    tbl[27] = '{6'b000000, 1'b1, 1'b0, tv(ST_DECODE, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0)};
    tbl[28] = '{6'b000000, 1'b1, 1'b0, tv(ST_RTEXE,  1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0)};
    tbl[29] = '{6'b000000, 1'b1, 1'b0, tv(ST_RTWB,   1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0)};

    // Reset state with mem_ready high: FETCH values, but no write enables
    mem_ready = 1'b1;
    opcode = 6'b100011;
    #2;
    n_vec++;
    if ({state, mem_req, ir_write, pc_write, reg_write, mem_we, illegal_op} !== {ST_FETCH, 6'b100000}) begin
      n_bad++;
      $display("FAIL reset_state: got %h/%b%b%b%b%b%b expected %h/100000", state, mem_req,
               ir_write, pc_write, reg_write, mem_we, illegal_op, ST_FETCH);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_reset();

    for (int i = 0; i < 30; i++) begin
      apply(tbl[i].op, tbl[i].rdy, tbl[i].z, 1'b1, tbl[i].exp, $sformatf("vec%0d", i));
    end

    // sw with three wait cycles in MEMWR: strobes held for four cycles
    apply(6'b101011, 1'b1, 1'b0, 1'b0, 13'd0, "sw_fetch");
    apply(6'b101011, 1'b1, 1'b0, 1'b0, 13'd0, "sw_decode");
    apply(6'b101011, 1'b1, 1'b0, 1'b0, 13'd0, "sw_memadr");
    hold = 0;
    for (int i = 0; i < 4; i++) begin
      apply(6'b101011, (i == 3), 1'b0, 1'b0, 13'd0, "sw_wait");
      if (last_act[21] && last_act[20] && last_act[19] && last_act[3:0] == ST_MEMWR) hold++;
    end
    #1;
    n_vec++;
    if (hold != 4 || state !== ST_FETCH) begin
      n_bad++;
      $display("FAIL sw_wait_hold: got %0d cycles then state %h, expected 4 cycles then %h",
               hold, state, ST_FETCH);
    end

    // Asynchronous reset in the middle of a stalled MEMWR
    apply(6'b101011, 1'b1, 1'b0, 1'b0, 13'd0, "rst_fetch");
    apply(6'b101011, 1'b1, 1'b0, 1'b0, 13'd0, "rst_decode");
    apply(6'b101011, 1'b1, 1'b0, 1'b0, 13'd0, "rst_memadr");
    apply(6'b101011, 1'b0, 1'b0, 1'b0, 13'd0, "rst_memwr");
    mem_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({state, mem_req, mem_we, reg_write, pc_write, ir_write} !== {ST_FETCH, 5'b10000}) begin
      n_bad++;
      $display("FAIL async_reset: got %h/%b%b%b%b%b expected %h/10000", state, mem_req,
               mem_we, reg_write, pc_write, ir_write, ST_FETCH);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();

    // Randomized instruction stream with random memory waits and zero flag
    rop = 6'b100011;
    for (int i = 0; i < 1500; i++) begin
      if (m_phase == ST_FETCH) begin
        rchk = 8'($urandom_range(0, 7));
        if (rchk == 8'd0) rop = 6'($urandom_range(0, 63));
        else rop = legal_ops[$urandom_range(0, 7)];
      end
      apply(rop, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0, 13'd0, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Moore-style control unit that sequences the shared datapath (PC, instruction/data memory port, register file, sign/zero extender, ALU) across multiple cycles per instruction. It replaces the single-cycle combinational decoder when the processor moves to a multicycle organisation. It also configures the immediate extender per opcode and stalls on a memory-ready handshake.

## Interface
- No parameters; opcode and state encodings come from the shared package.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instr[31:26] from the instruction register
- mem_ready  in  1  memory access complete this cycle
- zero  in  1  ALU zero flag, for beq
- mem_req  out  1  memory access in progress
- mem_we  out  1  write strobe, valid with mem_req
- iord  out  1  0 = PC address, 1 = ALUOut address
- ir_write, pc_write, pc_write_cond, reg_write  out  1 each  register enables
- reg_dst, mem_to_reg, alu_src_a  out  1 each  datapath mux selects
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = ext_imm, 11 = ext_imm<<2
- alu_op  out  2  00 = add, 01 = sub, 10 = funct-decode, 11 = logical, with funct taken from opcode
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- ext_sel  out  1  1 = sign-extend, 0 = zero-extend
- illegal_op  out  1  one-cycle pulse on unknown opcode
- state  out  4  current state, for debug

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXE, RTWB, BEQ, IMMEXE, IMMWB, JUMP.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write and pc_write are asserted only when mem_ready=1; this is the single Mealy qualification.
  - Stay in FETCH while mem_ready=0.
- DECODE: alu_src_a=0, alu_src_b=11, ext_sel=1, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 100011 lw, 101011 sw → MEMADR
  - 000000 R-type → RTEXE
  - 000100 beq → BEQ
  - 001000 addi, 001100 andi, 001101 ori → IMMEXE
  - 000010 j → JUMP
  - anything else → FETCH, with illegal_op=1 for one cycle.
- MEMADR: alu_src_a=1, alu_src_b=10, ext_sel=1, alu_op=00. lw → MEMRD, sw → MEMWR.
- MEMRD: mem_req=1, iord=1; hold until mem_ready, then → MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1 → FETCH.
- MEMWR: mem_req=1, mem_we=1, iord=1; hold until mem_ready, then → FETCH.
- RTEXE: alu_src_a=1, alu_src_b=00, alu_op=10 → RTWB.
- RTWB: reg_write=1, reg_dst=1, mem_to_reg=0 → FETCH.
- BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01 → FETCH. The datapath computes PC enable as pc_write | (pc_write_cond & zero).
- IMMEXE: alu_src_a=1, alu_src_b=10. addi: ext_sel=1, alu_op=00. andi/ori: ext_sel=0, alu_op=11. → IMMWB.
- IMMWB: reg_write=1, reg_dst=0, mem_to_reg=0 → FETCH.
- JUMP: pc_write=1, pc_src=10 → FETCH.
- Any output not listed for a state is 0; ext_sel defaults to 1.
- Reset: state=FETCH. All outputs carry their FETCH values, except ir_write and pc_write, which stay 0 until mem_ready. illegal_op=0.

## Timing
- Latency with mem_ready tied high:
  - lw 5 cycles
  - sw, R-type, addi/andi/ori 4 cycles
  - beq, j 3 cycles
- Each memory wait cycle adds one cycle in FETCH, MEMRD or MEMWR.
- mem_req stays high and address/selects stay stable for every wait cycle.
- mem_ready sampled outside FETCH/MEMRD/MEMWR is ignored.
- Asynchronous reset mid-instruction aborts immediately. No write enable may be asserted during reset; on release, fetch restarts.
- opcode is sampled only in DECODE and MEMADR; ir_write=0 elsewhere keeps it stable.

## Structure
- Shared package mips_pkg holds:
  - opcode constants
  - state encoding (4-bit localparams)
  - alu_op, alu_src_b and pc_src encodings
- One sub-module, mips_ctrl_outdec: a purely combinational state+opcode → control-vector decoder.
- Top module holds only the state register and the next-state logic.

## Test plan
- Reset: rst_n=0 mid-MEMWR → state=FETCH asynchronously; mem_we=0, reg_write=0, pc_write=0.
- lw (opcode 100011), mem_ready=1 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB. reg_write=1 and mem_to_reg=1 only in cycle 5.
- sw with mem_ready low 3 cycles in MEMWR → mem_req=1, mem_we=1, iord=1 held 4 cycles, then FETCH.
- beq with zero=1 and zero=0 → pc_write_cond=1, pc_src=01 in cycle 3; back in FETCH at cycle 4 in both cases.
- andi (001100) → ext_sel=0, alu_op=11 in IMMEXE. addi (001000) → ext_sel=1, alu_op=00.
- opcode 111111 → DECODE, then FETCH with one-cycle illegal_op=1 and no reg_write or mem_we.
